// File: rtl/sine_pwm_dac.sv
// Converts sine samples to an edge-aligned PWM stream through a one-deep pending buffer.
// Define SINE_PWM_CENTER_ALIGNED_EN for an up/down (centre-aligned) counter.
module sine_pwm_dac #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned PWM_WIDTH  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  sample_req,
    output logic                  pwm_out,
    output logic [PWM_WIDTH-1:0]  duty_active,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [PWM_WIDTH-1:0] CNT_MAX = {PWM_WIDTH{1'b1}};

    logic [1:0]           state, state_nxt;
    logic [PWM_WIDTH-1:0] cnt, cnt_nxt;
    logic [PWM_WIDTH-1:0] pending, pending_nxt;
    logic                 pending_valid, pending_valid_nxt;
    logic [PWM_WIDTH-1:0] duty_nxt;
    logic [PWM_WIDTH-1:0] data_mapped;
    logic                 overrun_nxt, underrun_nxt;
    logic                 busy_nxt, sample_req_nxt, pwm_nxt;
    logic                 at_end, load, period_end;
`ifdef SINE_PWM_CENTER_ALIGNED_EN
    logic                 dir_up, dir_up_nxt;
`endif

    // Align the sample MSB to the duty MSB (drop or zero-fill LSBs)
    generate
        if (DATA_WIDTH >= PWM_WIDTH) begin : g_trunc
            assign data_mapped = data_in[DATA_WIDTH-1 -: PWM_WIDTH];
        end else begin : g_pad
            assign data_mapped = {data_in, {(PWM_WIDTH-DATA_WIDTH){1'b0}}};
        end
    endgenerate

    // Next-state, counter, buffer and flag logic
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        pending_nxt       = pending;
        pending_valid_nxt = pending_valid;
        duty_nxt          = duty_active;
        overrun_nxt       = overrun;
        underrun_nxt      = underrun;
        at_end            = 1'b0;
        load              = 1'b0;
        period_end        = 1'b0;
`ifdef SINE_PWM_CENTER_ALIGNED_EN
        dir_up_nxt        = dir_up;
`endif

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
`ifdef SINE_PWM_CENTER_ALIGNED_EN
                dir_up_nxt = 1'b1;
`endif
                if (enable) begin
                    state_nxt = ST_RUN;
                    load      = pending_valid;
                end
            end
            ST_RUN, ST_DRAIN: begin
`ifdef SINE_PWM_CENTER_ALIGNED_EN
                // Counter dwells one cycle at each turnaround; period ends at zero on the way down
                if (dir_up) begin
                    if (cnt == CNT_MAX) begin
                        dir_up_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + PWM_WIDTH'(1);
                    end
                end else if (cnt == '0) begin
                    dir_up_nxt = 1'b1;
                    at_end     = 1'b1;
                end else begin
                    cnt_nxt = cnt - PWM_WIDTH'(1);
                end
`else
                cnt_nxt = cnt + PWM_WIDTH'(1);
                at_end  = (cnt == CNT_MAX);
`endif
                if (state == ST_RUN) begin
                    period_end = at_end;
                    load       = at_end;
                    if (!enable) begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (enable) begin
                    state_nxt = ST_RUN;
                end else if (at_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A transfer frees the pending slot, so a same-cycle write is never an overrun
        if (load && pending_valid) begin
            duty_nxt          = pending;
            pending_valid_nxt = data_valid;
            if (data_valid) begin
                pending_nxt = data_mapped;
            end
        end else if (period_end && data_valid) begin
            duty_nxt = data_mapped;
        end else if (period_end) begin
            underrun_nxt = 1'b1;
        end else if (data_valid) begin
            pending_nxt       = data_mapped;
            pending_valid_nxt = 1'b1;
            if (pending_valid) begin
                overrun_nxt = 1'b1;
            end
        end

        busy_nxt = (state_nxt != ST_IDLE);
`ifdef SINE_PWM_CENTER_ALIGNED_EN
        sample_req_nxt = (state_nxt == ST_RUN) && (cnt_nxt == '0) && dir_up_nxt;
`else
        sample_req_nxt = (state_nxt == ST_RUN) && (cnt_nxt == '0);
`endif
        pwm_nxt = busy && (cnt < duty_active);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            duty_active   <= '0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            busy          <= 1'b0;
            sample_req    <= 1'b0;
            pwm_out       <= 1'b0;
`ifdef SINE_PWM_CENTER_ALIGNED_EN
            dir_up        <= 1'b1;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pending       <= pending_nxt;
            pending_valid <= pending_valid_nxt;
            duty_active   <= duty_nxt;
            overrun       <= overrun_nxt;
            underrun      <= underrun_nxt;
            busy          <= busy_nxt;
            sample_req    <= sample_req_nxt;
            pwm_out       <= pwm_nxt;
`ifdef SINE_PWM_CENTER_ALIGNED_EN
            dir_up        <= dir_up_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Self-checking bench for sine_pwm_dac (4-bit data, 4-bit PWM, edge-aligned build).
module tb_sine_pwm_dac;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] data_in;
    logic       data_valid;
    logic       sample_req;
    logic       pwm_out;
    logic [3:0] duty_active;
    logic       overrun;
    logic       underrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sine_pwm_dac #(.DATA_WIDTH(4), .PWM_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .sample_req  (sample_req),
        .pwm_out     (pwm_out),
        .duty_active (duty_active),
        .overrun     (overrun),
        .underrun    (underrun),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: mode 0=idle, 1=run, 2=drain; pending sample kept in a queue of depth <=1
    int         m_mode;
    int         m_cnt;
    logic [3:0] pend_q[$];
    logic [3:0] m_duty;
    logic       m_pwm, m_sreq, m_ovr, m_und, m_busy;
    bit         m_wrap, m_load, m_bypass;

    always @(posedge clock) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; pend_q.delete(); m_duty = 4'd0;
            m_pwm = 1'b0; m_sreq = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_busy = 1'b0;
        end else begin
            m_pwm    = m_busy && (m_cnt < int'(m_duty));
            m_wrap   = (m_cnt == 15);
            m_load   = (m_mode == 1 && m_wrap) || (m_mode == 0 && enable && pend_q.size() != 0);
            m_bypass = 1'b0;
            if (m_load) begin
                if (pend_q.size() != 0) m_duty = pend_q.pop_front();
                else if (data_valid) begin m_duty = data_in; m_bypass = 1'b1; end
                else m_und = 1'b1;
                if (data_valid && !m_bypass) pend_q.push_back(data_in);
            end else if (data_valid) begin
                if (pend_q.size() != 0) begin m_ovr = 1'b1; void'(pend_q.pop_front()); end
                pend_q.push_back(data_in);
            end
            case (m_mode)
                0: if (enable) m_mode = 1;
                1: begin m_cnt = (m_cnt + 1) % 16; if (!enable) m_mode = 2; end
                default: begin
                    m_cnt = (m_cnt + 1) % 16;
                    if (enable) m_mode = 1;
                    else if (m_wrap) m_mode = 0;
                end
            endcase
            m_busy = (m_mode != 0);
            m_sreq = (m_mode == 1) && (m_cnt == 0);
        end
    end

    logic [8:0] outs, exp_outs;
    assign outs     = {sample_req, pwm_out, duty_active, overrun, underrun, busy};
    assign exp_outs = {m_sreq, m_pwm, m_duty, m_ovr, m_und, m_busy};

    task automatic apply_reset();
        enable = 1'b0; data_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic preload(input logic [3:0] v);
        data_in = v; data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; data_valid = 1'b1; data_in = 4'd9;
        repeat (2) @(negedge clock);
        checks++;
        if (outs !== 9'd0) begin
            errors++; $display("FAIL reset_state got %b want %b", outs, 9'd0);
        end
        checks++;
        if (outs !== exp_outs) begin
            errors++; $display("FAIL reset_model got %b want %b", outs, exp_outs);
        end
        reset = 1'b0; enable = 1'b0; data_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic_duty();
        int highs = 0;
        int sreqs = 0;
        apply_reset();
        preload(4'd5);
        enable = 1'b1;
        for (int k = 0; k < 49; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL basic_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if (k == 0) begin
                checks++;
                if (sample_req !== 1'b1 || duty_active !== 4'd5) begin
                    errors++; $display("FAIL basic_start got sreq=%b duty=%0d want sreq=1 duty=5", sample_req, duty_active);
                end
            end
            if (k >= 1 && pwm_out) highs++;
            if (k < 48 && sample_req) sreqs++;
            data_in = 4'd5; data_valid = (m_cnt == 3);
        end
        checks++;
        if (highs != 15 || sreqs != 3) begin
            errors++; $display("FAIL basic_counts got highs=%0d sreq=%0d want highs=15 sreq=3", highs, sreqs);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_limits();
        for (int d = 0; d < 16; d += 15) begin
            int highs = 0;
            apply_reset();
            preload(4'(d));
            enable = 1'b1;
            for (int k = 0; k < 33; k++) begin
                @(negedge clock);
                checks++;
                if (outs !== exp_outs) begin
                    errors++; $display("FAIL limits_lockstep d=%0d k=%0d got %b want %b", d, k, outs, exp_outs);
                end
                if (k >= 1 && pwm_out) highs++;
                data_in = 4'(d); data_valid = (m_cnt == 8);
            end
            checks++;
            if (highs != 2 * d || underrun !== 1'b0) begin
                errors++; $display("FAIL limits_duty d=%0d got highs=%0d underrun=%b want highs=%0d underrun=0", d, highs, underrun, 2 * d);
            end
            data_valid = 1'b0;
        end
    endtask

    task automatic test_handshake();
        apply_reset();
        preload(4'd7);
        enable = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL hs_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if (k == 6) begin
                checks++;
                if (overrun !== 1'b1) begin errors++; $display("FAIL hs_overrun got %b want 1", overrun); end
            end
            if (k == 16) begin
                checks++;
                if (duty_active !== 4'd9 || underrun !== 1'b0) begin
                    errors++; $display("FAIL hs_newest got duty=%0d und=%b want duty=9 und=0", duty_active, underrun);
                end
            end
            if (k == 32) begin
                checks++;
                if (duty_active !== 4'd9 || underrun !== 1'b1) begin
                    errors++; $display("FAIL hs_underrun got duty=%0d und=%b want duty=9 und=1", duty_active, underrun);
                end
            end
            data_valid = (k == 2) || (k == 5);
            data_in    = (k == 2) ? 4'd3 : 4'd9;
        end
        // Sample arriving exactly at cnt==MAX with pending empty goes straight to duty
        apply_reset();
        preload(4'd7);
        enable = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL bypass_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if (k == 16) begin
                checks++;
                if (duty_active !== 4'd11 || underrun !== 1'b0 || overrun !== 1'b0) begin
                    errors++; $display("FAIL bypass_load got duty=%0d und=%b ovr=%b want duty=11 und=0 ovr=0", duty_active, underrun, overrun);
                end
            end
            if (k == 32) begin
                checks++;
                if (duty_active !== 4'd11 || underrun !== 1'b1) begin
                    errors++; $display("FAIL bypass_empty got duty=%0d und=%b want duty=11 und=1", duty_active, underrun);
                end
            end
            data_in = 4'd11; data_valid = (k == 15);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_graceful_stop();
        int highs = 0;
        apply_reset();
        preload(4'd10);
        enable = 1'b1;
        for (int k = 0; k < 41; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL stop_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if (k >= 23 && k <= 31) begin
                if (pwm_out) highs++;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL stop_drain k=%0d got busy=%b want 1", k, busy); end
            end
            if (k == 32) begin
                checks++;
                if (busy !== 1'b0 || pwm_out !== 1'b0 || sample_req !== 1'b0) begin
                    errors++; $display("FAIL stop_idle got busy=%b pwm=%b sreq=%b want 0 0 0", busy, pwm_out, sample_req);
                end
            end
            if (k == 22) enable = 1'b0;
            data_in = 4'd10; data_valid = m_busy && (m_cnt == 3);
        end
        checks++;
        if (highs != 4) begin errors++; $display("FAIL stop_pulses got %0d want 4", highs); end
        // Re-raising enable before the period ends keeps the modulator running
        apply_reset();
        preload(4'd10);
        enable = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs || busy !== 1'b1) begin
                errors++; $display("FAIL resume_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if (k == 16 || k == 32) begin
                checks++;
                if (sample_req !== 1'b1) begin errors++; $display("FAIL resume_sreq k=%0d got %b want 1", k, sample_req); end
            end
            if (k == 6) enable = 1'b0;
            if (k == 10) enable = 1'b1;
            data_in = 4'd10; data_valid = (m_cnt == 3);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        preload(4'd12);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL rmid_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            data_in = 4'd12; data_valid = (k == 3);
            if (k == 7) reset = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (outs !== 9'd0 || outs !== exp_outs) begin
            errors++; $display("FAIL rmid_clear got %b want %b", outs, 9'd0);
        end
        reset = 1'b0; enable = 1'b1;
        @(negedge clock);
        checks++;
        if (duty_active !== 4'd0 || busy !== 1'b1 || sample_req !== 1'b1) begin
            errors++; $display("FAIL rmid_pending got duty=%0d busy=%b sreq=%b want duty=0 busy=1 sreq=1", duty_active, busy, sample_req);
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        enable = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clock);
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL random_lockstep k=%0d got %b want %b", k, outs, exp_outs);
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            data_valid = ($urandom_range(0, 7) == 0);
            data_in    = 4'($urandom_range(0, 15));
            reset      = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0; enable = 1'b0; data_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = 4'd0;
        test_reset();
        test_basic_duty();
        test_limits();
        test_handshake();
        test_graceful_stop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
